// File: rtl/rob_commit_unit_pkg.sv
// Shared sizing and entry/request types for the ROB commit unit.
package rob_commit_unit_pkg;
  localparam int RRF_NUM   = 64;
  localparam int RRF_SEL   = 6;
  localparam int REG_SEL   = 5;
  localparam int FIN_PORTS = 5;

  typedef logic [RRF_SEL-1:0] rrftag_t;
  typedef logic [REG_SEL-1:0] regnum_t;
  typedef logic [RRF_SEL:0]   cnt_t;

  typedef struct packed {
    logic    valid;
    logic    finished;
    logic    dst_en;
    regnum_t dstnum;
  } rob_entry_t;

  typedef struct packed {
    logic    we;
    rrftag_t tag;
    logic    dst_en;
    regnum_t dstnum;
  } dp_req_t;
endpackage

// File: rtl/rob_commit_unit_entry_array.sv
// ROB entry storage: dispatch write, finish set, commit clear, head read.
module rob_entry_array
  import rob_commit_unit_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  dp_req_t                      dp_i,
  input  logic    [FIN_PORTS-1:0]      fin_we_i,
  input  rrftag_t [FIN_PORTS-1:0]      fin_tag_i,
  input  logic                         clr_we_i,
  input  rrftag_t                      clr_tag_i,
  input  rrftag_t                      head_tag_i,
  output rob_entry_t                   head_o,
  output logic                         dp_tgt_valid_o
);

  rob_entry_t ent [RRF_NUM];

  for (genvar i = 0; i < RRF_NUM; i++) begin : g_ent
    rob_entry_t ent_q;
    logic       fin_hit, dp_hit, clr_hit;

    always_comb begin
      fin_hit = 1'b0;
      for (int k = 0; k < FIN_PORTS; k++)
        if (fin_we_i[k] && fin_tag_i[k] == rrftag_t'(i)) fin_hit = 1'b1;
    end

    assign dp_hit  = dp_i.we && (dp_i.tag == rrftag_t'(i));
    assign clr_hit = clr_we_i && (clr_tag_i == rrftag_t'(i));

    // Dispatch wins over a same-cycle commit clear (full-ring wrap reuse).
    always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
        ent_q <= '0;
      end else if (dp_hit) begin
        ent_q.valid    <= 1'b1;
        ent_q.finished <= fin_hit;
        ent_q.dst_en   <= dp_i.dst_en;
        ent_q.dstnum   <= dp_i.dstnum;
      end else if (clr_hit) begin
        ent_q.valid    <= 1'b0;
        ent_q.finished <= 1'b0;
      end else if (fin_hit && ent_q.valid) begin
        ent_q.finished <= 1'b1;
      end
    end

    assign ent[i] = ent_q;
  end

  assign head_o         = ent[head_tag_i];
  assign dp_tgt_valid_o = ent[dp_i.tag].valid;

endmodule

// File: rtl/rob_commit_unit.sv
// In-order retirement: tracks renamed instructions and retires one per cycle.
// Optional ROB_PERF_CNT_EN adds a 32-bit retired-instruction counter.
module rob_commit_unit
  import rob_commit_unit_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           dp_we_i,
  input  logic [RRF_SEL-1:0]             dp_rrftag_i,
  input  logic                           dp_dst_en_i,
  input  logic [REG_SEL-1:0]             dp_dstnum_i,
  input  logic [FIN_PORTS-1:0]           fin_we_i,
  input  logic [FIN_PORTS*RRF_SEL-1:0]   fin_rrftag_i,
  output logic [1:0]                     com_inst_num_o,
  output logic                           completed_we_o,
  output logic [REG_SEL-1:0]             completed_dstnum_o,
  output logic [RRF_SEL-1:0]             completed_dst_rrftag_o,
  output logic [RRF_SEL-1:0]             comptr_o,
  output logic                           rob_empty_o
`ifdef ROB_PERF_CNT_EN
  , output logic [31:0]                  perf_commit_cnt_o
`endif
);

  rrftag_t                 comptr_q, comptr_d;
  cnt_t                    cnt_q, cnt_d;
  rob_entry_t              head;
  logic                    commit, dp_tgt_valid;
  dp_req_t                 dp;
  rrftag_t [FIN_PORTS-1:0] fin_tags;

  assign dp       = '{we: dp_we_i, tag: dp_rrftag_i, dst_en: dp_dst_en_i, dstnum: dp_dstnum_i};
  assign fin_tags = fin_rrftag_i;

  rob_entry_array u_arr (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .dp_i           (dp),
    .fin_we_i       (fin_we_i),
    .fin_tag_i      (fin_tags),
    .clr_we_i       (commit),
    .clr_tag_i      (comptr_q),
    .head_tag_i     (comptr_q),
    .head_o         (head),
    .dp_tgt_valid_o (dp_tgt_valid)
  );

  // Commit depends only on registered entry state.
  assign commit                 = head.valid && head.finished;
  assign com_inst_num_o         = {1'b0, commit};
  assign completed_we_o         = commit && head.dst_en;
  assign completed_dstnum_o     = commit ? head.dstnum : '0;
  assign completed_dst_rrftag_o = commit ? comptr_q : '0;
  assign comptr_o               = comptr_q;
  assign rob_empty_o            = (cnt_q == '0);

  assign comptr_d = comptr_q + rrftag_t'(commit);

  always_comb begin
    cnt_d = cnt_q;
    if (dp_we_i && !commit) begin
      if (cnt_q != cnt_t'(RRF_NUM)) cnt_d = cnt_q + cnt_t'(1);
    end else if (!dp_we_i && commit) begin
      cnt_d = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      comptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      comptr_q <= comptr_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) perf_q <= '0;
    else          perf_q <= perf_q + 32'(commit);
  end
  assign perf_commit_cnt_o = perf_q;
`endif

  // The allocator never hands out a live tag, except the one retiring now.
  a_no_live_overwrite: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(dp_we_i && dp_tgt_valid && !(commit && dp_rrftag_i == comptr_q)));

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed vector table, multi-cycle corner sequences and a randomized run
// checked against a program-order queue model.
module tb_rob_commit_unit;
  import rob_commit_unit_pkg::*;

  logic                         clk_i = 1'b0;
  logic                         reset_i = 1'b0;
  logic                         dp_we_i = 1'b0;
  logic [RRF_SEL-1:0]           dp_rrftag_i = '0;
  logic                         dp_dst_en_i = 1'b0;
  logic [REG_SEL-1:0]           dp_dstnum_i = '0;
  logic [FIN_PORTS-1:0]         fin_we_i = '0;
  logic [FIN_PORTS*RRF_SEL-1:0] fin_rrftag_i = '0;
  logic [1:0]                   com_inst_num_o;
  logic                         completed_we_o;
  logic [REG_SEL-1:0]           completed_dstnum_o;
  logic [RRF_SEL-1:0]           completed_dst_rrftag_o;
  logic [RRF_SEL-1:0]           comptr_o;
  logic                         rob_empty_o;
`ifdef ROB_PERF_CNT_EN
  logic [31:0]                  perf_commit_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  rob_commit_unit dut (
    .clk_i                  (clk_i),
    .reset_i                (reset_i),
    .dp_we_i                (dp_we_i),
    .dp_rrftag_i            (dp_rrftag_i),
    .dp_dst_en_i            (dp_dst_en_i),
    .dp_dstnum_i            (dp_dstnum_i),
    .fin_we_i               (fin_we_i),
    .fin_rrftag_i           (fin_rrftag_i),
    .com_inst_num_o         (com_inst_num_o),
    .completed_we_o         (completed_we_o),
    .completed_dstnum_o     (completed_dstnum_o),
    .completed_dst_rrftag_o (completed_dst_rrftag_o),
    .comptr_o               (comptr_o),
    .rob_empty_o            (rob_empty_o)
`ifdef ROB_PERF_CNT_EN
    , .perf_commit_cnt_o    (perf_commit_cnt_o)
`endif
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input bit com, input bit we, input int dn,
                         input int tag, input int ptr, input bit emp);
    chk({nm, " com"},   32'(com_inst_num_o),         32'(com));
    chk({nm, " we"},    32'(completed_we_o),         32'(we));
    chk({nm, " dstnum"},32'(completed_dstnum_o),     32'(dn));
    chk({nm, " tag"},   32'(completed_dst_rrftag_o), 32'(tag));
    chk({nm, " ptr"},   32'(comptr_o),               32'(ptr));
    chk({nm, " empty"}, 32'(rob_empty_o),            32'(emp));
  endtask

  task automatic drive(input bit dpwe, input int tag, input bit dsten, input int dn,
                       input logic [4:0] fwe, input logic [4:0][5:0] ft);
    dp_we_i      = dpwe;
    dp_rrftag_i  = RRF_SEL'(tag);
    dp_dst_en_i  = dsten;
    dp_dstnum_i  = REG_SEL'(dn);
    fin_we_i     = fwe;
    fin_rrftag_i = ft;
  endtask

  task automatic idle();
    drive(1'b0, 0, 1'b0, 0, 5'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    idle();
    reset_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  typedef struct {
    bit             dpwe;
    int             dptag;
    bit             dsten;
    int             dn;
    logic [4:0]     fwe;
    logic [4:0][5:0] ft;
    bit             com;
    bit             we;
    int             edn;
    int             etag;
    int             eptr;
    bit             emp;
  } vec_t;

  function automatic vec_t V(bit dpwe, int dptag, bit dsten, int dn, logic [4:0] fwe,
                             int t0, int t1, int t2, int t3, int t4,
                             bit com, bit we, int edn, int etag, int eptr, bit emp);
    vec_t v;
    v.dpwe = dpwe; v.dptag = dptag; v.dsten = dsten; v.dn = dn; v.fwe = fwe;
    v.ft[0] = 6'(t0); v.ft[1] = 6'(t1); v.ft[2] = 6'(t2); v.ft[3] = 6'(t3); v.ft[4] = 6'(t4);
    v.com = com; v.we = we; v.edn = edn; v.etag = etag; v.eptr = eptr; v.emp = emp;
    return v;
  endfunction

  typedef struct {
    logic [5:0] tag;
    bit         dst_en;
    logic [4:0] dn;
    bit         fin;
  } ment_t;

  ment_t      q[$];
  logic [5:0] hp;
  int         ncom;

  localparam int NV = 24;
  vec_t vt [NV];

  initial begin
    // expected outputs are those visible just after the edge that applies the row
    vt[0]  = V(1,0,1,5,  5'b00000, 0,0,0,0,0, 0,0,0,0,0,0);
    vt[1]  = V(0,0,0,0,  5'b00001, 0,0,0,0,0, 1,1,5,0,0,0);
    vt[2]  = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 0,0,0,0,1,1);
    vt[3]  = V(1,1,1,1,  5'b00000, 0,0,0,0,0, 0,0,0,0,1,0);
    vt[4]  = V(1,2,1,2,  5'b00000, 0,0,0,0,0, 0,0,0,0,1,0);
    vt[5]  = V(1,3,1,3,  5'b01000, 0,0,0,3,0, 0,0,0,0,1,0);
    vt[6]  = V(0,0,0,0,  5'b00100, 0,0,2,0,0, 0,0,0,0,1,0);
    vt[7]  = V(0,0,0,0,  5'b00010, 0,1,0,0,0, 1,1,1,1,1,0);
    vt[8]  = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 1,1,2,2,2,0);
    vt[9]  = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 1,1,3,3,3,0);
    vt[10] = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 0,0,0,0,4,1);
    vt[11] = V(1,4,0,9,  5'b00000, 0,0,0,0,0, 0,0,0,0,4,0);
    vt[12] = V(0,0,0,0,  5'b10000, 0,0,0,0,4, 1,0,9,4,4,0);
    vt[13] = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 0,0,0,0,5,1);
    vt[14] = V(1,5,1,7,  5'b00001, 5,0,0,0,0, 1,1,7,5,5,0);
    vt[15] = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 0,0,0,0,6,1);
    vt[16] = V(0,0,0,0,  5'b00101, 6,0,6,0,0, 0,0,0,0,6,1);
    vt[17] = V(1,6,1,4,  5'b00000, 0,0,0,0,0, 0,0,0,0,6,0);
    vt[18] = V(0,0,0,0,  5'b01001, 6,0,0,6,0, 1,1,4,6,6,0);
    vt[19] = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 0,0,0,0,7,1);
    vt[20] = V(1,7,1,10, 5'b00000, 0,0,0,0,0, 0,0,0,0,7,0);
    vt[21] = V(1,8,1,11, 5'b00101, 7,0,8,0,0, 1,1,10,7,7,0);
    vt[22] = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 1,1,11,8,8,0);
    vt[23] = V(0,0,0,0,  5'b00000, 0,0,0,0,0, 0,0,0,0,9,1);

    // reset then idle
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    chk_out("reset", 0, 0, 0, 0, 0, 1);
`ifdef ROB_PERF_CNT_EN
    chk("reset perf", perf_commit_cnt_o, 32'd0);
`endif

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vt[i].dpwe, vt[i].dptag, vt[i].dsten, vt[i].dn, vt[i].fwe, vt[i].ft);
      @(posedge clk_i); #1;
      chk_out($sformatf("vec%0d", i), vt[i].com, vt[i].we, vt[i].edn, vt[i].etag,
              vt[i].eptr, vt[i].emp);
    end

    // async reset in the middle of live traffic
    @(negedge clk_i);
    drive(1'b1, 9, 1'b1, 3, 5'b00001, {6'd0, 6'd0, 6'd0, 6'd0, 6'd9});
    @(posedge clk_i); #1;
    chk_out("pre-rst", 1, 1, 3, 9, 9, 0);
    @(negedge clk_i);
    drive(1'b1, 10, 1'b1, 4, 5'b0, '0);
    @(posedge clk_i); #2;
    idle();
    reset_i = 1'b0;
    #1;
    chk_out("mid-rst", 0, 0, 0, 0, 0, 1);
`ifdef ROB_PERF_CNT_EN
    chk("mid-rst perf", perf_commit_cnt_o, 32'd0);
`endif
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    drive(1'b0, 0, 1'b0, 0, 5'b00001, {6'd0, 6'd0, 6'd0, 6'd0, 6'd10});
    @(posedge clk_i); #1;
    chk_out("post-rst", 0, 0, 0, 0, 0, 1);

    // wrap: walk the head to 63, then retire 63 and 0
    for (int i = 0; i < 63; i++) begin
      @(negedge clk_i);
      drive(1'b1, i, 1'b1, i % 32, 5'b00001, {24'd0, 6'(i)});
    end
    @(negedge clk_i);
    idle();
    @(posedge clk_i); #1;
    chk_out("preload", 0, 0, 0, 0, 63, 1);
    @(negedge clk_i);
    drive(1'b1, 63, 1'b1, 1, 5'b0, '0);
    @(negedge clk_i);
    drive(1'b1, 0, 1'b1, 2, 5'b0, '0);
    @(negedge clk_i);
    drive(1'b0, 0, 1'b0, 0, 5'b00011, {6'd0, 6'd0, 6'd0, 6'd0, 6'd63});
    @(posedge clk_i); #1;
    chk_out("wrap63", 1, 1, 1, 63, 63, 0);
    @(negedge clk_i);
    idle();
    @(posedge clk_i); #1;
    chk_out("wrap0", 1, 1, 2, 0, 0, 0);
    @(posedge clk_i); #1;
    chk_out("wrap1", 0, 0, 0, 0, 1, 1);

    // randomized traffic against a program-order queue model
    do_reset();
    q.delete();
    hp = '0;
    ncom = 0;
    for (int c = 0; c < 3000; c++) begin
      bit              cm, dpwe, dsten;
      logic [5:0]      nt;
      logic [4:0]      dn, fwe;
      logic [4:0][5:0] ft;
      int              pr;
      @(negedge clk_i);
      cm = (q.size() > 0) && q[0].fin;
      chk_out($sformatf("rnd%0d", c), cm, cm && q[0].dst_en, cm ? int'(q[0].dn) : 0,
              cm ? int'(q[0].tag) : 0, int'(hp), q.size() == 0);
      nt    = hp + 6'(q.size());
      dpwe  = ($urandom % 2 == 1) && (q.size() < RRF_NUM || cm);
      dsten = ($urandom % 4 != 0);
      dn    = 5'($urandom);
      pr    = ((c / 300) % 2 == 1) ? 40 : 3;
      fwe   = '0;
      ft    = '0;
      for (int k = 0; k < FIN_PORTS; k++) begin
        if ($urandom_range(99) < pr) begin
          fwe[k] = 1'b1;
          if (dpwe && $urandom % 8 == 0)            ft[k] = nt;
          else if (q.size() > 0 && $urandom % 4 != 0) ft[k] = q[$urandom_range(q.size() - 1)].tag;
          else                                      ft[k] = 6'($urandom);
        end
      end
      drive(dpwe, int'(nt), dsten, int'(dn), fwe, ft);
      @(posedge clk_i);
      if (cm) begin
        void'(q.pop_front());
        hp = hp + 6'd1;
        ncom++;
      end
      for (int k = 0; k < FIN_PORTS; k++)
        if (fwe[k])
          for (int j = 0; j < q.size(); j++)
            if (q[j].tag == ft[k]) q[j].fin = 1'b1;
      if (dpwe) begin
        ment_t e;
        e.tag = nt; e.dst_en = dsten; e.dn = dn; e.fin = 1'b0;
        for (int k = 0; k < FIN_PORTS; k++)
          if (fwe[k] && ft[k] == nt) e.fin = 1'b1;
        q.push_back(e);
      end
    end
    @(negedge clk_i);
    idle();
    chk("rnd ptr", 32'(comptr_o), 32'(hp));
`ifdef ROB_PERF_CNT_EN
    chk("perf", perf_commit_cnt_o, 32'(ncom));
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
